ln_row_scheduler: RTL and testbench

//  Sequences token rows (64 x 16b) from an upstream ready/valid stream into the LayerNorm core. The core is a

---
 rtl/ln_row_scheduler_if.sv | 11 +
 rtl/ln_row_scheduler.sv | 131 +++++++++++++
 tb/tb_ln_row_scheduler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ln_row_scheduler_if.sv
// Upstream row stream between the fetch path and the LayerNorm row scheduler.
interface ln_row_scheduler_if #(
  parameter int ROW_W = 1024
);
  logic             s_valid;
  logic             s_ready;
  logic [ROW_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ln_row_scheduler.sv
// Issues token rows into the fixed-latency LayerNorm core under output-buffer credits,
// counts rows per job and checks that every core result returns exactly LN_LATENCY cycles later.
module ln_row_scheduler #(
  parameter int ROW_W      = 1024,
  parameter int LN_LATENCY = 26,
  parameter int OBUF_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_num_rows,
  ln_row_scheduler_if.slave   s_if,
  output logic                o_ln_en,
  output logic                o_ln_valid,
  output logic [ROW_W-1:0]    o_ln_data,
  input  logic                i_ln_valid,
  input  logic                i_obuf_pop,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int CRED_W = $clog2(OBUF_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(OBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      num_rows_q;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      returned_q, returned_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic [LN_LATENCY-1:0] track_q;
  logic                  ln_valid_q;
  logic [ROW_W-1:0]      ln_data_q;

  logic accept, pop_ok, ret_ok, tail;

  assign s_if.s_ready = (state_q == S_RUN) && (credits_q != '0) && (issued_q < num_rows_q);
  assign accept       = s_if.s_valid & s_if.s_ready;
  // A pop into a full credit pool is only legal when an accept consumes one in the same cycle.
  assign pop_ok       = i_obuf_pop & ((credits_q != CRED_MAX) | accept);
  assign ret_ok       = i_ln_valid & (state_q != S_IDLE);
  assign tail         = track_q[LN_LATENCY-1];

  always_comb begin
    credits_d = credits_q;
    unique case ({accept, pop_ok})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  assign issued_d   = issued_q + CNT_W'(accept);
  assign returned_d = (ret_ok && (returned_q != '1)) ? returned_q + CNT_W'(1) : returned_q;
  assign err_d      = err_q | (i_ln_valid ^ tail) | (i_ln_valid & (state_q == S_IDLE))
                    | (i_obuf_pop & ~pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      num_rows_q <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      credits_q  <= CRED_MAX;
      track_q    <= '0;
      ln_valid_q <= 1'b0;
      ln_data_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= err_d;
      credits_q  <= credits_d;
      // Issue stage: one register between accept and the core input.
      ln_valid_q <= accept;
      if (accept) ln_data_q <= s_if.s_data;
      track_q    <= {track_q[LN_LATENCY-2:0], ln_valid_q};

      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            num_rows_q <= i_num_rows;
            issued_q   <= '0;
            returned_q <= '0;
            if (i_num_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          issued_q   <= issued_d;
          returned_q <= returned_d;
          if (issued_d == num_rows_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          returned_q <= returned_d;
          if (returned_d == num_rows_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ln_valid = ln_valid_q;
  assign o_ln_data  = ln_data_q;
  assign o_ln_en    = busy_q | (|track_q);
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_ln_row_scheduler.sv
// Scoreboard bench for ln_row_scheduler: random rows and pops, a fixed-latency core model,
// and a credit/row-count reference model driving the expected handshake.
module tb_ln_row_scheduler;
  localparam int ROW_W = 1024;
  localparam int LAT   = 26;
  localparam int DEPTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_rows = '0;
  logic             ln_ret = 1'b0;
  logic             pop = 1'b0;
  logic             ln_en, ln_valid, busy, done, err;
  logic [ROW_W-1:0] ln_data;

  ln_row_scheduler_if #(.ROW_W(ROW_W)) sif();

  ln_row_scheduler #(.ROW_W(ROW_W), .LN_LATENCY(LAT), .OBUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_rows(num_rows), .s_if(sif),
    .o_ln_en(ln_en), .o_ln_valid(ln_valid), .o_ln_data(ln_data), .i_ln_valid(ln_ret),
    .i_obuf_pop(pop), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ROW_W-1:0] exp_q[$];
  int ret_q[$];
  int done_q[$];

  int lat = LAT;
  bit inject = 1'b0;
  int done_target = -1;
  int zero_done_cyc = -1;
  int ret_total = 0, last_ret_cyc = 0;
  int ln_seen = 0, busy_seen = 0, done_seen = 0, err_rise_cyc = -1;
  bit err_prev = 1'b0;

  int m_cred = DEPTH, m_issued = 0, m_n = 0;
  bit running = 1'b0, m_err = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Core model and output monitor.
  initial forever begin
    @(posedge clk); #2;
    if (!rst_n) begin
      ret_q.delete();
      ln_ret = 1'b0;
    end else begin
      ln_ret = inject;
      if (ret_q.size() != 0 && ret_q[0] == cyc) begin
        void'(ret_q.pop_front());
        ln_ret = 1'b1;
        ret_total++;
        last_ret_cyc = cyc;
        if (ret_total == done_target) done_q.push_back(cyc + 1);
      end
    end
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      done_q.delete();
      err_prev = 1'b0;
    end else begin
      if (ln_valid) begin
        ln_seen++;
        ret_q.push_back(cyc + lat);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL o_ln_valid: got unexpected row, required none (t=%0t)", $time);
        end else begin
          logic [ROW_W-1:0] e;
          e = exp_q.pop_front();
          n_cmp++;
          if (ln_data !== e) begin
            n_bad++;
            $display("FAIL o_ln_data: got %h required %h (low 64b, t=%0t)", ln_data[63:0], e[63:0], $time);
          end
        end
      end
      if (busy) busy_seen++;
      if (done) begin
        done_seen++;
        if (done_q.size() != 0) chk("o_done cycle", cyc, done_q.pop_front());
        else chk("o_done cycle", cyc, zero_done_cyc);
      end
      if (err && !err_prev) err_rise_cyc = cyc;
      err_prev = err;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst o_busy", busy, 0);
    chk("rst o_done", done, 0);
    chk("rst o_ln_valid", ln_valid, 0);
    chk("rst o_ln_en", ln_en, 0);
    chk("rst s_ready", sif.s_ready, 0);
    chk("rst o_err", err, 0);
    chk("rst o_ln_data nonzero", |ln_data, 0);
    start = 1'b0; sif.s_valid = 1'b0; pop = 1'b0; inject = 1'b0; lat = LAT;
    m_cred = DEPTH; m_issued = 0; m_n = 0; running = 1'b0; m_err = 1'b0;
    done_target = -1; zero_done_cyc = -1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // vmode: 0 idle, 1 always valid, 2 random; pmode: 0 none, 1 eager, 2 random, 3 forced
  task automatic step(input int vmode, input int pmode);
    bit rdy, sv, acc, pp;
    logic [ROW_W-1:0] d;
    rdy = running && (m_issued < m_n) && (m_cred > 0);
    chk("s_ready", sif.s_ready, rdy);
    sv = (vmode == 1) || (vmode == 2 && $urandom_range(0, 1) == 1);
    for (int i = 0; i < ROW_W / 32; i++) d[i*32 +: 32] = $urandom;
    acc = sv && rdy;
    case (pmode)
      1:       pp = (m_cred < DEPTH);
      2:       pp = (m_cred < DEPTH) && ($urandom_range(0, 2) != 0);
      3:       pp = 1'b1;
      default: pp = 1'b0;
    endcase
    if (acc) begin
      exp_q.push_back(d);
      m_issued++;
    end
    if (acc && !pp) m_cred--;
    else if (pp && !acc) begin
      if (m_cred == DEPTH) m_err = 1'b1;
      else m_cred++;
    end
    sif.s_valid = sv; sif.s_data = d; pop = pp;
    tick();
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    num_rows = CNT_W'(n);
    zero_done_cyc = (n == 0) ? cyc + 1 : -1;
    if (n != 0) done_target = ret_total + n;
    step(0, 0);
    start = 1'b0;
    running = (n != 0);
    m_n = n;
    m_issued = 0;
  endtask

  task automatic wait_done(input int vmode, input int pmode, input int bound);
    int s, k;
    s = done_seen;
    k = 0;
    while (done_seen == s && k < bound) begin
      step(vmode, pmode);
      k++;
    end
    chk("job done within bound", done_seen > s, 1);
    running = 1'b0;
    chk("pending o_done", done_q.size(), 0);
    chk("pending rows", exp_q.size(), 0);
  endtask

  initial begin
    int base, base_b, base_d, n;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    do_reset();

    // T1: 4 rows, eager pops
    base = ln_seen;
    start_job(4);
    wait_done(1, 1, 200);
    chk("T1 rows issued", ln_seen - base, 4);
    chk("T1 o_err", err, m_err);
    repeat (3) step(0, 1);
    chk("T1 o_ln_en after drain", ln_en, 0);
    chk("T1 o_busy after drain", busy, 0);

    // T2: 40 rows with no pops stalls at 32
    base = ln_seen;
    start_job(40);
    repeat (36) step(1, 0);
    chk("T2 accepts before pops", ln_seen - base, 32);
    repeat (8) step(1, 3);
    wait_done(1, 1, 300);
    chk("T2 rows issued", ln_seen - base, 40);
    chk("T2 o_err", err, m_err);

    // T3: zero-row job
    base = ln_seen; base_b = busy_seen; base_d = done_seen;
    start_job(0);
    chk("T3 o_done next cycle", done, 1);
    repeat (4) step(0, 0);
    chk("T3 o_busy cycles", busy_seen - base_b, 0);
    chk("T3 o_ln_valid cycles", ln_seen - base, 0);
    chk("T3 o_done pulses", done_seen - base_d, 1);

    // Random jobs
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 60);
      base = ln_seen;
      start_job(n);
      wait_done(2, 2, 3000);
      chk("RND rows issued", ln_seen - base, n);
      chk("RND o_err", err, m_err);
    end

    // T4: accept+pop at one credit, then pop into a full pool
    repeat (40) step(0, 1);
    start_job(40);
    repeat (31) step(1, 0);
    step(1, 3);
    step(1, 0);
    step(1, 0);
    wait_done(1, 1, 300);
    repeat (5) step(0, 1);
    chk("T4 o_err before extra pop", err, 0);
    step(0, 3);
    step(0, 0);
    chk("T4 o_err after extra pop", err, m_err);
    base = ln_seen;
    start_job(40);
    repeat (36) step(1, 0);
    chk("T4 credits after extra pop", ln_seen - base, 32);
    wait_done(1, 1, 300);

    // T5: core one cycle early, then a return in IDLE
    do_reset();
    lat = LAT - 1;
    start_job(1);
    wait_done(1, 1, 100);
    chk("T5 o_err rise cycle", err_rise_cyc, last_ret_cyc + 1);
    chk("T5 o_err early return", err, 1);
    do_reset();
    step(0, 0);
    chk("T5 o_err before inject", err, 0);
    inject = 1'b1;
    step(0, 0);
    inject = 1'b0;
    step(0, 0);
    chk("T5 o_err idle return", err, 1);

    // T6: reset mid-run, then a fresh job
    do_reset();
    start_job(20);
    for (int k = 0; k < 40 && m_issued < 10; k++) step(1, 1);
    chk("T6 rows before reset", m_issued, 10);
    do_reset();
    chk("T6 o_busy after release", busy, 0);
    base = ln_seen;
    start_job(2);
    wait_done(1, 1, 100);
    chk("T6 rows issued", ln_seen - base, 2);
    chk("T6 o_err", err, 0);

    repeat (3) step(0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
